// File: rtl/if_slice.sv
// Instruction-fetch stage: owns the PC, fetches from a req/ack instruction memory and
// hands {instr, PC+1} to decode, with a one-entry skid buffer to absorb stalls.
module if_slice #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [15:0] instr_out,
  output logic [15:0] PC_inc_out,
  output logic        valid_out,
  output logic        halted
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   instr_q, instr_d;
  logic [W-1:0]   pcinc_q, pcinc_d;
  logic [W-1:0]   buf_instr_q, buf_instr_d;
  logic [W-1:0]   buf_pcinc_q, buf_pcinc_d;
  logic           valid_q, valid_d;
  logic           halted_q, halted_d;
  logic [W-1:0]   pc_plus1;
  logic           rdata_is_halt;
  logic           buf_is_halt;

  assign pc_plus1      = pc_q + W'(1);
  assign rdata_is_halt = (imem_rdata[W-1:W-4] == HALT_OP);
  assign buf_is_halt   = (buf_instr_q[W-1:W-4] == HALT_OP);

  // Request is a state decode, but must drop immediately while reset is held
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign instr_out  = instr_q;
  assign PC_inc_out = pcinc_q;
  assign valid_out  = valid_q;
  assign halted     = halted_q;

  // Next-state: redirect beats stall beats normal flow
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pcinc_d     = pcinc_q;
    buf_instr_d = buf_instr_q;
    buf_pcinc_d = buf_pcinc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;

    if (redirect) begin
      state_d     = S_FETCH;
      pc_d        = redirect_pc;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      halted_d    = 1'b0;
      buf_instr_d = NOP_INSTR;
      buf_pcinc_d = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack && stall) begin
            buf_instr_d = imem_rdata;
            buf_pcinc_d = pc_plus1;
            state_d     = S_HOLD;
          end else if (imem_ack) begin
            instr_d = imem_rdata;
            pcinc_d = pc_plus1;
            valid_d = 1'b1;
            if (rdata_is_halt) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_plus1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_d = buf_instr_q;
            pcinc_d = buf_pcinc_q;
            valid_d = 1'b1;
            if (buf_is_halt) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d    = pc_plus1;
              state_d = S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pcinc_q     <= '0;
      buf_instr_q <= NOP_INSTR;
      buf_pcinc_q <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcinc_q     <= pcinc_d;
      buf_instr_q <= buf_instr_d;
      buf_pcinc_q <= buf_pcinc_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: tb/tb_if_slice.sv
// Randomized scoreboard bench for if_slice: a memory model answers fetches, a transaction
// model predicts delivered instructions, and a monitor checks what decode sees.
module tb_if_slice;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [3:0]  HLT = 4'hF;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcinc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        imem_ack = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] PC_inc_out;
  logic        valid_out;
  logic        halted;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  // Transaction model state
  item_t       sb_q[$];
  logic [15:0] m_pc = 16'h0000;
  logic        m_hold = 1'b0;
  logic        m_hold_hlt = 1'b0;
  logic        m_halt = 1'b0;
  logic        pre_halt = 1'b0;

  if_slice dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr_out  (instr_out),
    .PC_inc_out (PC_inc_out),
    .valid_out  (valid_out),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return h[31:16] ^ a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned p_ack, input int unsigned p_stall,
                      input int unsigned p_red, input int unsigned p_rst);
    logic        cur_req;
    logic [15:0] cur_addr;
    logic        exp_req;
    logic [15:0] w;
    @(negedge clk);
    exp_req = rst_n && !m_hold && !m_halt;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    cur_req  = imem_req;
    cur_addr = imem_addr;

    rst_n    = ($urandom_range(99) >= p_rst);
    redirect = ($urandom_range(99) < p_red);
    case ($urandom_range(3))
      0:       redirect_pc = 16'hFFFF;
      1:       redirect_pc = 16'hFFFE;
      default: redirect_pc = 16'($urandom);
    endcase
    stall      = ($urandom_range(99) < p_stall);
    imem_ack   = cur_req && ($urandom_range(99) < p_ack);
    imem_rdata = imem_ack ? mem_word(cur_addr) : 16'($urandom);
    pre_halt   = m_halt;

    // Predict the effect of the coming edge
    if (!rst_n) begin
      m_pc = 16'h0000; m_hold = 1'b0; m_halt = 1'b0;
      sb_q.delete();
    end else if (redirect) begin
      m_pc = redirect_pc; m_hold = 1'b0; m_halt = 1'b0;
      sb_q.delete();
    end else if (m_hold) begin
      if (!stall) begin
        m_hold = 1'b0;
        if (m_hold_hlt) m_halt = 1'b1;
        else            m_pc = m_pc + 16'd1;
      end
    end else if (!m_halt && imem_ack) begin
      w = mem_word(m_pc);
      sb_q.push_back('{instr: w, pcinc: m_pc + 16'd1});
      if (stall) begin
        m_hold     = 1'b1;
        m_hold_hlt = (w[15:12] == HLT);
      end else if (w[15:12] == HLT) begin
        m_halt = 1'b1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic run_phase(input int unsigned n, input int unsigned p_ack,
                           input int unsigned p_stall, input int unsigned p_red,
                           input int unsigned p_rst);
    for (int i = 0; i < int'(n); i++) step(p_ack, p_stall, p_red, p_rst);
  endtask

  // Monitor: tracks what decode should currently be seeing
  logic        hv = 1'b0;
  logic [15:0] hi = NOP;
  logic [15:0] hp = 16'h0;

  always @(posedge clk) begin
    logic  s_rst, s_red, s_stall, s_halt;
    item_t it;
    s_rst   = rst_n;
    s_red   = redirect;
    s_stall = stall;
    s_halt  = pre_halt;
    #1;
    if (!s_rst) begin
      hv = 1'b0; hi = NOP; hp = 16'h0;
    end else if (s_red) begin
      hv = 1'b0; hi = NOP;
    end else if (!s_stall && !s_halt) begin
      if (valid_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_instr: got %h expected none at %0t", instr_out, $time);
        end else begin
          it = sb_q.pop_front();
          hv = 1'b1; hi = it.instr; hp = it.pcinc;
        end
      end else begin
        chk("bubble_pending", 32'(sb_q.size()), 32'd0);
        hv = 1'b0; hi = NOP;
      end
    end
    chk("valid_out", 32'(valid_out), 32'(hv));
    chk("instr_out", 32'(instr_out), 32'(hi));
    if (hv || !s_rst) chk("PC_inc_out", 32'(PC_inc_out), 32'(hp));
  end

  initial begin
    run_phase(2,    0,   0,  0,  100);
    run_phase(30,   100, 0,  0,  0);
    run_phase(40,   40,  0,  0,  0);
    run_phase(3000, 60,  30, 5,  1);
    run_phase(1500, 90,  50, 12, 0);
    run_phase(200,  100, 20, 3,  0);
    run_phase(10,   0,   0,  0,  0);
    @(negedge clk);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
